// File: rtl/gtreset_seq_pkg.sv
// Shared types and defaults for the GT reset master sequencer.
// The optional re-arm feature is enabled by GTRESET_SEQ_REARM_EN in gtreset_seq.sv.
package gtreset_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4,
        ST_FAIL = 3'd5
    } state_e;

    localparam int TOUT_W = 20;
    localparam int GAP_W  = 16;

    localparam logic [TOUT_W-1:0] DEF_TIMEOUT  = 20'd500000;
    localparam logic [GAP_W-1:0]  DEF_GAPLEN   = 16'd64;
    localparam int                DEF_MAXRETRY = 3;
    localparam int                DEF_RETRYW   = 2;

endpackage

// File: rtl/gtreset_seq_timer.sv
// Loadable down-counter that holds at zero; used for the stage timeout and the settle gap.
module gtreset_seq_timer #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load has priority over decrement; the count never wraps below zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != {W{1'b0}})) begin
            count_d = count_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == {W{1'b0}});

endmodule

// File: rtl/gtreset_seq.sv
// Master GT reset sequencer: requests each stage in order, with timeout, retry and settle gap.
// Define GTRESET_SEQ_REARM_EN to re-sequence from a stage whose done level falls while DONE.
module gtreset_seq
    import gtreset_seq_pkg::*;
#(
    parameter int                NSTAGE   = 4,
    parameter int                STAGEW   = 2,
    parameter logic [TOUT_W-1:0] TIMEOUT  = DEF_TIMEOUT,
    parameter logic [GAP_W-1:0]  GAPLEN   = DEF_GAPLEN,
    parameter int                MAXRETRY = DEF_MAXRETRY,
    parameter int                RETRYW   = DEF_RETRYW
) (
    input  logic              stableclk,
    input  logic              reset,
    input  logic              start,
    input  logic [NSTAGE-1:0] stage_done,
    input  logic [NSTAGE-1:0] stage_donestrobe,
    output logic [NSTAGE-1:0] stage_req,
    output logic              busy,
    output logic              all_done,
    output logic              all_done_strobe,
    output logic              fail,
    output logic [STAGEW-1:0] fail_stage,
    output logic [STAGEW-1:0] cur_stage,
    output logic [RETRYW-1:0] retry_cnt
);

    function automatic logic [NSTAGE-1:0] stage_onehot(input logic [STAGEW-1:0] idx);
        logic [NSTAGE-1:0] v;
        v = {NSTAGE{1'b0}};
        for (int i = 0; i < NSTAGE; i++) begin
            v[i] = (idx == STAGEW'(i));
        end
        return v;
    endfunction

    state_e            state_q, state_d;
    logic [STAGEW-1:0] cur_q, cur_d;
    logic [RETRYW-1:0] retry_q, retry_d;
    logic [STAGEW-1:0] fail_stage_q, fail_stage_d;
    logic [NSTAGE-1:0] stage_req_q;
    logic              busy_q;
    logic              all_done_q;
    logic              all_done_strobe_q;
    logic              fail_q;

    logic              strobe_s;
    logic              tout_load_s, tout_en_s, tout_zero_s;
    logic              gap_load_s, gap_en_s, gap_zero_s;
    logic              rearm_s;
    logic [STAGEW-1:0] rearm_stage_s;

    assign strobe_s = |(stage_donestrobe & stage_onehot(cur_q));

`ifdef GTRESET_SEQ_REARM_EN
    function automatic logic [STAGEW-1:0] lowest_set(input logic [NSTAGE-1:0] v);
        logic [STAGEW-1:0] idx;
        idx = {STAGEW{1'b0}};
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = STAGEW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [NSTAGE-1:0] done_prev_q;
    logic [NSTAGE-1:0] done_fall_s;

    // Previous stage_done levels; cleared by reset so no edge is seen right after it.
    always_ff @(posedge stableclk) begin
        if (reset) begin
            done_prev_q <= {NSTAGE{1'b0}};
        end else begin
            done_prev_q <= stage_done;
        end
    end

    assign done_fall_s   = done_prev_q & ~stage_done;
    assign rearm_s       = |done_fall_s;
    assign rearm_stage_s = lowest_set(done_fall_s);
`else
    logic unused_stage_done_s;
    assign unused_stage_done_s = ^stage_done;
    assign rearm_s             = 1'b0;
    assign rearm_stage_s       = {STAGEW{1'b0}};
`endif

    gtreset_seq_timer #(.W(TOUT_W)) u_tout (
        .clk_i      (stableclk),
        .rst_i      (reset),
        .load_i     (tout_load_s),
        .load_val_i (TIMEOUT),
        .en_i       (tout_en_s),
        .zero_o     (tout_zero_s)
    );

    gtreset_seq_timer #(.W(GAP_W)) u_gap (
        .clk_i      (stableclk),
        .rst_i      (reset),
        .load_i     (gap_load_s),
        .load_val_i (GAPLEN),
        .en_i       (gap_en_s),
        .zero_o     (gap_zero_s)
    );

    // Next-state logic; start in any non-idle state restarts from stage 0.
    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        retry_d      = retry_q;
        fail_stage_d = fail_stage_q;
        tout_load_s  = 1'b0;
        tout_en_s    = 1'b0;
        gap_load_s   = 1'b0;
        gap_en_s     = 1'b0;
        if (start) begin
            state_d = ST_REQ;
            cur_d   = {STAGEW{1'b0}};
            retry_d = {RETRYW{1'b0}};
            if (state_q == ST_REQ) begin
                tout_load_s = 1'b1;
            end else begin
                tout_load_s = 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_REQ: begin
                    tout_load_s = 1'b1;
                    state_d     = ST_WAIT;
                end
                ST_WAIT: begin
                    // A strobe on the expiry cycle still counts as done.
                    if (strobe_s) begin
                        gap_load_s = 1'b1;
                        state_d    = ST_GAP;
                    end else if (tout_zero_s) begin
                        if (retry_q < RETRYW'(MAXRETRY)) begin
                            retry_d = retry_q + {{(RETRYW-1){1'b0}}, 1'b1};
                            state_d = ST_REQ;
                        end else begin
                            fail_stage_d = cur_q;
                            state_d      = ST_FAIL;
                        end
                    end else begin
                        tout_en_s = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_zero_s) begin
                        if (cur_q == STAGEW'(NSTAGE - 1)) begin
                            state_d = ST_DONE;
                        end else begin
                            cur_d   = cur_q + {{(STAGEW-1){1'b0}}, 1'b1};
                            retry_d = {RETRYW{1'b0}};
                            state_d = ST_REQ;
                        end
                    end else begin
                        gap_en_s = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (rearm_s) begin
                        cur_d   = rearm_stage_s;
                        retry_d = {RETRYW{1'b0}};
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and registered outputs; outputs are decoded from the next state so they align with it.
    always_ff @(posedge stableclk) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            cur_q             <= {STAGEW{1'b0}};
            retry_q           <= {RETRYW{1'b0}};
            fail_stage_q      <= {STAGEW{1'b0}};
            stage_req_q       <= {NSTAGE{1'b0}};
            busy_q            <= 1'b0;
            all_done_q        <= 1'b0;
            all_done_strobe_q <= 1'b0;
            fail_q            <= 1'b0;
        end else begin
            state_q           <= state_d;
            cur_q             <= cur_d;
            retry_q           <= retry_d;
            fail_stage_q      <= fail_stage_d;
            stage_req_q       <= (state_d == ST_REQ) ? stage_onehot(cur_d) : {NSTAGE{1'b0}};
            busy_q            <= (state_d == ST_REQ) || (state_d == ST_WAIT) || (state_d == ST_GAP);
            all_done_q        <= (state_d == ST_DONE);
            all_done_strobe_q <= (state_d == ST_DONE) && (state_q != ST_DONE);
            fail_q            <= (state_d == ST_FAIL);
        end
    end

    assign stage_req       = stage_req_q;
    assign busy            = busy_q;
    assign all_done        = all_done_q;
    assign all_done_strobe = all_done_strobe_q;
    assign fail            = fail_q;
    assign fail_stage      = fail_stage_q;
    assign cur_stage       = cur_q;
    assign retry_cnt       = retry_q;

endmodule

// File: tb/tb_gtreset_seq.sv
// Scoreboard bench for gtreset_seq: expected request pulses are queued, a responder strobes done.
module tb_gtreset_seq;

    localparam int NST = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [NST-1:0] stage_done;
    logic [NST-1:0] stage_donestrobe = 4'b0000;
    logic [NST-1:0] stage_req;
    logic           busy, all_done, all_done_strobe, fail;
    logic [1:0]     fail_stage, cur_stage, retry_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0;
    int delay_a [NST];
    int due_a   [NST];

    typedef struct {
        int stage;
        int at;
    } req_t;
    req_t exp_q[$];
    req_t exp_e;

    gtreset_seq #(
        .NSTAGE(4), .STAGEW(2), .TIMEOUT(20'd20), .GAPLEN(16'd4), .MAXRETRY(3), .RETRYW(2)
    ) dut (
        .stableclk        (clk),
        .reset            (reset),
        .start            (start),
        .stage_done       (stage_done),
        .stage_donestrobe (stage_donestrobe),
        .stage_req        (stage_req),
        .busy             (busy),
        .all_done         (all_done),
        .all_done_strobe  (all_done_strobe),
        .fail             (fail),
        .fail_stage       (fail_stage),
        .cur_stage        (cur_stage),
        .retry_cnt        (retry_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_req(input int stage, input int at);
        req_t r;
        r.stage = stage;
        r.at    = at;
        exp_q.push_back(r);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Monitor pops the scoreboard on every request pulse; responder strobes done after delay_a cycles.
    always @(negedge clk) begin
        if (stage_req != 4'b0000) begin
            if (exp_q.size() == 0) begin
                check_eq("req_unexpected", int'(stage_req), 0);
            end else begin
                exp_e = exp_q.pop_front();
                check_eq("req_stage", int'(stage_req), 1 << exp_e.stage);
                check_eq("req_cycle", cyc, exp_e.at);
            end
            for (int k = 0; k < NST; k++) begin
                if (stage_req[k] && delay_a[k] > 0) due_a[k] = cyc + delay_a[k];
            end
        end
        for (int k = 0; k < NST; k++) stage_donestrobe[k] = (due_a[k] == cyc);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        stage_done = 4'b1111;
        for (int k = 0; k < NST; k++) begin
            delay_a[k] = 9;
            due_a[k]   = -1;
        end
        repeat (3) step();
        check_eq("rst_req",    int'(stage_req), 0);
        check_eq("rst_busy",   int'(busy), 0);
        check_eq("rst_done",   int'(all_done), 0);
        check_eq("rst_dstb",   int'(all_done_strobe), 0);
        check_eq("rst_fail",   int'(fail), 0);
        check_eq("rst_fstage", int'(fail_stage), 0);
        check_eq("rst_cur",    int'(cur_stage), 0);
        check_eq("rst_retry",  int'(retry_cnt), 0);
        reset = 1'b0;
        step();

        // Normal sequence: done strobe 9 cycles after each request -> 15-cycle spacing.
        t0 = cyc;
        for (int k = 0; k < NST; k++) push_req(k, t0 + 1 + 15 * k);
        pulse_start();
        check_eq("s1_busy_req", int'(busy), 1);
        wait_until(t0 + 60);
        check_eq("s1_busy_gap", int'(busy), 1);
        check_eq("s1_done_gap", int'(all_done), 0);
        step();
        check_eq("s1_done",    int'(all_done), 1);
        check_eq("s1_busy_dn", int'(busy), 0);
        check_eq("s1_dstb",    int'(all_done_strobe), 1);
        step();
        check_eq("s1_dstb_once", int'(all_done_strobe), 0);
        check_eq("s1_done_hold", int'(all_done), 1);

        // Stage 1 never answers: four requests 22 cycles apart, then FAIL.
        delay_a[1] = 0;
        t0 = cyc;
        push_req(0, t0 + 1);
        for (int i = 0; i < 4; i++) push_req(1, t0 + 16 + 22 * i);
        pulse_start();
        check_eq("s2_done_clr", int'(all_done), 0);
        wait_until(t0 + 60);
        check_eq("s2_retry2", int'(retry_cnt), 2);
        check_eq("s2_cur",    int'(cur_stage), 1);
        wait_until(t0 + 103);
        check_eq("s2_fail_pre", int'(fail), 0);
        check_eq("s2_busy_pre", int'(busy), 1);
        step();
        check_eq("s2_fail",   int'(fail), 1);
        check_eq("s2_fstage", int'(fail_stage), 1);
        check_eq("s2_retry3", int'(retry_cnt), 3);
        check_eq("s2_busy",   int'(busy), 0);

        // Stage 2 strobes exactly on its expiry cycle: treated as done, no retry.
        delay_a[1] = 9;
        delay_a[2] = 21;
        t0 = cyc;
        push_req(0, t0 + 1);
        push_req(1, t0 + 16);
        push_req(2, t0 + 31);
        push_req(3, t0 + 58);
        pulse_start();
        check_eq("s3_fail_clr", int'(fail), 0);
        wait_until(t0 + 52);
        check_eq("s3_retry_exp", int'(retry_cnt), 0);
        wait_until(t0 + 58);
        check_eq("s3_retry_s3", int'(retry_cnt), 0);
        check_eq("s3_cur",      int'(cur_stage), 3);
        wait_until(t0 + 73);
        check_eq("s3_done", int'(all_done), 1);
        check_eq("s3_dstb", int'(all_done_strobe), 1);
        delay_a[2] = 9;

        // Restart during WAIT of stage 2; a stale stage-2 strobe later hits stage 1's WAIT.
        delay_a[2] = 30;
        t0 = cyc;
        push_req(0, t0 + 1);
        push_req(1, t0 + 16);
        push_req(2, t0 + 31);
        for (int k = 0; k < NST; k++) push_req(k, t0 + 37 + 15 * k);
        pulse_start();
        wait_until(t0 + 36);
        pulse_start();
        check_eq("s4_cur0",   int'(cur_stage), 0);
        check_eq("s4_retry0", int'(retry_cnt), 0);
        check_eq("s4_busy",   int'(busy), 1);
        delay_a[2] = 9;
        wait_until(t0 + 97);
        check_eq("s4_done", int'(all_done), 1);

        // Reset during GAP of stage 1, then a clean full run.
        t0 = cyc;
        push_req(0, t0 + 1);
        push_req(1, t0 + 16);
        pulse_start();
        wait_until(t0 + 27);
        reset = 1'b1;
        step();
        check_eq("s5_req",   int'(stage_req), 0);
        check_eq("s5_busy",  int'(busy), 0);
        check_eq("s5_cur",   int'(cur_stage), 0);
        check_eq("s5_done",  int'(all_done), 0);
        check_eq("s5_fail",  int'(fail), 0);
        check_eq("s5_retry", int'(retry_cnt), 0);
        reset = 1'b0;
        step();
        t0 = cyc;
        for (int k = 0; k < NST; k++) push_req(k, t0 + 1 + 15 * k);
        pulse_start();
        wait_until(t0 + 61);
        check_eq("s5_redone", int'(all_done), 1);
        repeat (3) step();

        // Falling stage_done[2] while DONE.
        t0 = cyc;
`ifdef GTRESET_SEQ_REARM_EN
        push_req(2, t0 + 1);
        push_req(3, t0 + 16);
`endif
        stage_done[2] = 1'b0;
        step();
        stage_done[2] = 1'b1;
`ifdef GTRESET_SEQ_REARM_EN
        check_eq("s6_done_clr", int'(all_done), 0);
        check_eq("s6_cur",      int'(cur_stage), 2);
        wait_until(t0 + 31);
        check_eq("s6_redone", int'(all_done), 1);
        check_eq("s6_dstb",   int'(all_done_strobe), 1);
`else
        wait_until(t0 + 40);
        check_eq("s6_hold_done", int'(all_done), 1);
        check_eq("s6_hold_busy", int'(busy), 0);
`endif

        repeat (4) step();
        check_eq("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
